i2c_burst_reader: RTL
=====================

I2C_BURST_READER -- requirements
Module: i2c_burst_reader

Interface
REQ-001 The block SHALL have parameter NBYTES, default 2, the number of bytes read per transaction, legal range 1..8.
REQ-002 The block SHALL have parameter SADR, default 7'h10, the 7-bit slave address.
REQ-003 The block SHALL have parameter PTR_EN, default 0, which when 1 writes a register pointer before the read (repeated start).
REQ-004 The block SHALL have parameter PRER, default 16'h00C8, the prescale value programmed into the core.
REQ-005 The block SHALL have parameter TMO, default 65535, the watchdog limit in clk cycles per byte transfer.
REQ-006 The block SHALL have ports, listed as name, direction, width, meaning:
- clk, in, 1: clock.
- arst, in, 1: reset, asynchronous, active-low.
- rst, in, 1: synchronous reset, active-high.
- start, in, 1: one-cycle transaction request.
- ptr, in, 8: register pointer, sampled at start.
- busy, out, 1: high from accepted start until done or err.
- done, out, 1: one-cycle pulse, data valid.
- err, out, 1: one-cycle pulse, transaction aborted.
- err_code, out, 2: 1 = NACK, 2 = arbitration lost, 3 = timeout.
- data, out, 8*NBYTES: received bytes, first byte in the MSBs.
- prer_o, out, 16: PRER constant.
- ctr_o, out, 8: 8'h80, core enable.
- txr_o, out, 8: core transmit register.
- cr_o, out, 8: core command register.
- cs_o, out, 1: core register strobe.
- ack_i, in, 1: core strobe acknowledge.
- sr_i, in, 8: core status; bit 1 = TIP, bit 5 = AL, bit 7 = RxACK.
- rxr_i, in, 8: core receive register.

Function
REQ-007 Every core write SHALL hold cs_o high until ack_i is sampled high, then drive cs_o low for at least one cycle.
REQ-008 After every command, the FSM SHALL wait for one of these, in the priority order given:
- sr_i[5] high: abort with AL.
- watchdog reaching TMO: abort with timeout.
- sr_i[1] low: proceed.
REQ-009 The watchdog SHALL be cleared at each command issue.
REQ-010 The FSM states SHALL be INIT, INACK, IDLE, AW, PTRW, AR, RD, WAIT, DATA, ABORT.
REQ-011 Out of reset the FSM SHALL run INIT -> INACK (core programmed with PRER and ctr 8'h80) -> IDLE.
REQ-012 In IDLE, start SHALL be accepted: busy rises the next cycle and ptr is latched.
REQ-013 If PTR_EN=1, the transaction SHALL issue these commands in order:
- AW: txr {SADR,0}, cr 8'h90.
- PTRW: txr ptr, cr 8'h10.
- then continue to AR.
REQ-014 AR SHALL issue txr {SADR,1} with cr 8'h90.
REQ-015 RD SHALL issue cr 8'h20 for bytes 0..NBYTES-2 and cr 8'h68 (read, NACK, STOP) for the last byte.
REQ-016 After each write command completes, sr_i[7] high (slave NACK) SHALL cause ABORT with code 1.
REQ-017 After each read completes, rxr_i SHALL be stored into byte slot idx and idx incremented.
- idx is a 3-bit counter reset to 0 at start.
REQ-018 DATA SHALL pulse done and clear busy in the cycle after the last byte's TIP falls, then return to IDLE.
REQ-019 ABORT SHALL issue cr 8'h40 (STOP) through the cs handshake without waiting for TIP, pulse err with err_code, clear busy, and return to IDLE.
REQ-020 data SHALL hold its last value until the next done.
- Partial bytes from an aborted transaction SHALL NOT be visible on data.
REQ-021 start SHALL be ignored while busy or while in INIT/INACK.
REQ-022 done and err SHALL never be high in the same cycle.
REQ-023 cr_o SHALL be 8'h00 whenever cs_o is low.

Reset
REQ-024 arst low or rst high SHALL force:
- state = INIT, idx = 0.
- cs_o = 0, cr_o = 0, txr_o = 0.
- busy = 0, done = 0, err = 0, err_code = 0, data = 0.
REQ-025 Reset mid-transaction SHALL abandon the bus without issuing STOP and SHALL re-run INIT.

Structure
REQ-026 A shared package i2c_pkg SHALL hold:
- cr command constants (STA 8'h80, STO 8'h40, RD 8'h20, WR 8'h10, NACK 8'h08).
- sr bit indices (TIP, AL, RxACK).
- the err_code encodings.
REQ-027 The block SHALL have no sub-module; the parent SHALL instantiate i2c_master_top next to it and connect the core register ports.

Verification
REQ-028 With NBYTES=2 and PTR_EN=0, the bench SHALL check that start with a slave model returning 8'hA5, 8'h3C gives:
- cr sequence 90, 20, 68.
- data = 16'hA53C.
- done pulses once.
REQ-029 With PTR_EN=1 and ptr = 8'h07, the bench SHALL check that:
- the slave sees W-address, 07, repeated start, R-address.
- for NBYTES=4, data equals the four model bytes in order.
REQ-030 With the slave NACKing the address, the bench SHALL check:
- err pulses with err_code 1.
- cr 8'h40 is issued.
- data is unchanged and busy is low.
REQ-031 With sr_i[5] forced high during byte 1, the bench SHALL check for err with code 2 and a return to IDLE.
REQ-032 With TMO=100 and TIP stuck high, the bench SHALL check for err with code 3 exactly 100 cycles after the command ack.
REQ-033 The bench SHALL check that arst asserted in the middle of RD zeroes all outputs in the same cycle, and that after release INIT completes and a new start succeeds.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared constants for the wishbone-less I2C core register interface:
// command bits, status bit positions, abort codes and the reader FSM states.
package i2c_pkg;

    localparam logic [7:0] CR_STA  = 8'h80;
    localparam logic [7:0] CR_STO  = 8'h40;
    localparam logic [7:0] CR_RD   = 8'h20;
    localparam logic [7:0] CR_WR   = 8'h10;
    localparam logic [7:0] CR_NACK = 8'h08;

    localparam int SR_TIP   = 1;
    localparam int SR_AL    = 5;
    localparam int SR_RXACK = 7;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_NACK = 2'd1,
        ERR_AL   = 2'd2,
        ERR_TMO  = 2'd3
    } err_code_t;

    typedef enum logic [3:0] {
        INIT, INACK, IDLE, AW, PTRW, AR, RD, WAIT, DATA, ABORT
    } state_t;

endpackage

// File: rtl/i2c_burst_reader.sv
// Burst reader driving an I2C master core's register port: optional pointer
// write with repeated start, then NBYTES reads delivered together on done.
module i2c_burst_reader
    import i2c_pkg::*;
#(
    parameter int          NBYTES = 2,
    parameter logic [6:0]  SADR   = 7'h10,
    parameter int          PTR_EN = 0,
    parameter logic [15:0] PRER   = 16'h00C8,
    parameter int          TMO    = 65535
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            ptr,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic [8*NBYTES-1:0]   data,
    output logic [15:0]           prer_o,
    output logic [7:0]            ctr_o,
    output logic [7:0]            txr_o,
    output logic [7:0]            cr_o,
    output logic                  cs_o,
    input  logic                  ack_i,
    input  logic [7:0]            sr_i,
    input  logic [7:0]            rxr_i
);

    localparam logic [2:0]  LAST      = 3'(NBYTES - 1);
    localparam logic [31:0] WDOG_LAST = 32'(TMO - 1);

    state_t      state, state_next, cmd;
    err_code_t   abort_code;
    logic [2:0]  idx;
    logic [7:0]  ptr_q;
    logic [31:0] wdog;
    logic [7:0]  rx_buf [8];
    logic        rd_done;
    logic        sr_unused;

    assign prer_o    = PRER;
    assign ctr_o     = 8'h80;
    assign sr_unused = ^{sr_i[6], sr_i[4:2], sr_i[0]};
    assign rd_done   = (state == WAIT) && (cmd == RD) &&
                       ((state_next == RD) || (state_next == DATA));

    always_ff @(posedge clk or negedge arst) begin
        if (!arst)
            state <= INIT;
        else if (rst)
            state <= INIT;
        else
            state <= state_next;
    end

    // WAIT serves every command; cmd remembers which one is in flight.
    always_comb begin
        state_next = state;
        abort_code = ERR_NONE;
        unique case (state)
            INIT:  state_next = INACK;
            INACK: if (ack_i) state_next = IDLE;
            IDLE:  if (start) state_next = (PTR_EN != 0) ? AW : AR;
            AW, PTRW, AR, RD: if (ack_i) state_next = WAIT;
            WAIT: begin
                if (sr_i[SR_AL]) begin
                    state_next = ABORT;
                    abort_code = ERR_AL;
                end else if (wdog == WDOG_LAST) begin
                    state_next = ABORT;
                    abort_code = ERR_TMO;
                end else if (!sr_i[SR_TIP]) begin
                    if (cmd == RD)
                        state_next = (idx == LAST) ? DATA : RD;
                    else if (sr_i[SR_RXACK]) begin
                        state_next = ABORT;
                        abort_code = ERR_NACK;
                    end else
                        state_next = (cmd == AW) ? PTRW : (cmd == PTRW) ? AR : RD;
                end
            end
            DATA:  state_next = IDLE;
            ABORT: if (ack_i) state_next = IDLE;
            default: state_next = INIT;
        endcase
    end

    always_comb begin
        cs_o  = 1'b0;
        cr_o  = 8'h00;
        txr_o = 8'h00;
        busy  = 1'b0;
        done  = 1'b0;
        err   = 1'b0;
        unique case (state)
            INACK: cs_o = 1'b1;
            AW: begin
                cs_o = 1'b1; cr_o = CR_STA | CR_WR; txr_o = {SADR, 1'b0}; busy = 1'b1;
            end
            PTRW: begin
                cs_o = 1'b1; cr_o = CR_WR; txr_o = ptr_q; busy = 1'b1;
            end
            AR: begin
                cs_o = 1'b1; cr_o = CR_STA | CR_WR; txr_o = {SADR, 1'b1}; busy = 1'b1;
            end
            RD: begin
                cs_o = 1'b1; busy = 1'b1;
                cr_o = (idx == LAST) ? (CR_RD | CR_NACK | CR_STO) : CR_RD;
            end
            WAIT: busy = 1'b1;
            DATA: done = 1'b1;
            ABORT: begin
                cs_o = 1'b1; cr_o = CR_STO; busy = 1'b1; err = ack_i;
            end
            default: ;
        endcase
    end

    // data is only rewritten on the final byte so aborted bursts never leak.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            idx <= '0; ptr_q <= '0; cmd <= INIT; wdog <= '0; err_code <= '0; data <= '0;
        end else if (rst) begin
            idx <= '0; ptr_q <= '0; cmd <= INIT; wdog <= '0; err_code <= '0; data <= '0;
        end else begin
            if (state == IDLE && start) begin
                idx      <= '0;
                ptr_q    <= ptr;
                err_code <= ERR_NONE;
            end
            if (cs_o && ack_i) begin
                cmd  <= state;
                wdog <= '0;
            end else if (state == WAIT)
                wdog <= wdog + 32'd1;
            if (state == WAIT && state_next == ABORT)
                err_code <= abort_code;
            if (rd_done) begin
                idx <= idx + 3'd1;
                if (state_next == DATA)
                    for (int i = 0; i < NBYTES; i++)
                        data[8*(NBYTES-1-i) +: 8] <= (idx == 3'(i)) ? rxr_i : rx_buf[3'(i)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_done)
            rx_buf[idx] <= rxr_i;
    end

endmodule
